// File: rtl/ecc_serial_tx_if.sv
// Producer-side bundle of the ECC serial transmitter: the word handshake
// into the block plus the serial line and its status outputs.
interface ecc_serial_tx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_WIDTH-1:0]       in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        tx_line;
    logic                        busy;
    logic                        frame_done;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  tx_line,
        input  busy,
        input  frame_done,
        input  fifo_level
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output tx_line,
        output busy,
        output frame_done,
        output fifo_level
    );
endinterface

// File: rtl/ecc_serial_tx.sv
// SECDED-encoding serial transmitter: words are encoded on push, queued as codewords
// and sent LSB-first in START/13 DATA/STOP frames. Error injection under ECC_TX_ERR_INJECT_EN.
module ecc_serial_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int ECC_WIDTH  = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
`ifdef ECC_TX_ERR_INJECT_EN
    input  logic       inject_err,
    input  logic [3:0] inject_bit,
`endif
    ecc_serial_tx_if.slave bus
);
    localparam int CW_WIDTH = DATA_WIDTH + ECC_WIDTH;
    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW       = $clog2(FIFO_DEPTH) + 1;
    localparam int CNTW     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [CNTW-1:0] LAST_CYCLE = CNTW'(BIT_CYCLES - 1);
    localparam logic [3:0]      LAST_BIT   = 4'(CW_WIDTH - 1);
    localparam logic [LW-1:0]   FULL_LEVEL = LW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic logic [CW_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [ECC_WIDTH-1:0] e;
        e[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        e[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        e[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
        e[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
        e[4] = ^{d, e[3:0]};
        return {e, d};
    endfunction

    logic [CW_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wrPtr_q, rdPtr_q;
    logic [LW-1:0]       count_q, count_d;

    logic [1:0]          state_q, state_d;
    logic [CNTW-1:0]     cycCnt_q, cycCnt_d;
    logic [3:0]          bitIdx_q, bitIdx_d;
    logic [CW_WIDTH-1:0] shift_q, shift_d;
    logic                txLine_q, txLine_d;
    logic                busy_q, busy_d;
    logic                frameDone_q, frameDone_d;

    logic                inReady;
    logic                push;
    logic                pop;
    logic                lastCycle;
    logic                fifoEmpty;
    logic [CW_WIDTH-1:0] injMask;
    logic [CW_WIDTH-1:0] headWord;

    // Ready looks only at the registered count, so a pop in a full cycle
    // cannot reopen the input until the following cycle.
    assign inReady   = (count_q != FULL_LEVEL);
    assign push      = bus.in_valid && inReady;
    assign fifoEmpty = (count_q == '0);
    assign lastCycle = (cycCnt_q == LAST_CYCLE);

`ifdef ECC_TX_ERR_INJECT_EN
    always_comb begin
        injMask = '0;
        if (inject_err && (inject_bit <= LAST_BIT)) begin
            injMask = CW_WIDTH'(1) << inject_bit;
        end
    end
`else
    assign injMask = '0;
`endif

    // The flip is applied only to the outgoing copy; the queued codeword stays intact.
    assign headWord = mem_q[rdPtr_q] ^ injMask;

    always_comb begin
        state_d  = state_q;
        cycCnt_d = cycCnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        txLine_d = txLine_q;
        busy_d   = busy_q;
        pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    pop      = 1'b1;
                    state_d  = ST_START;
                    shift_d  = headWord;
                    txLine_d = 1'b0;
                    busy_d   = 1'b1;
                    cycCnt_d = '0;
                    bitIdx_d = '0;
                end
            end
            ST_START: begin
                if (lastCycle) begin
                    state_d  = ST_DATA;
                    cycCnt_d = '0;
                    bitIdx_d = '0;
                    txLine_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                end else begin
                    cycCnt_d = cycCnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (lastCycle) begin
                    cycCnt_d = '0;
                    if (bitIdx_q == LAST_BIT) begin
                        state_d  = ST_STOP;
                        txLine_d = 1'b1;
                    end else begin
                        bitIdx_d = bitIdx_q + 1'b1;
                        txLine_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end else begin
                    cycCnt_d = cycCnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (lastCycle) begin
                    cycCnt_d = '0;
                    if (!fifoEmpty) begin
                        // Chain straight into the next frame with no idle gap.
                        pop      = 1'b1;
                        state_d  = ST_START;
                        shift_d  = headWord;
                        txLine_d = 1'b0;
                        busy_d   = 1'b1;
                        bitIdx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cycCnt_d = cycCnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cycCnt_d = '0;
                bitIdx_d = '0;
                txLine_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // Registering frame_done from next-state values makes it land in the final STOP clock.
    assign frameDone_d = (state_d == ST_STOP) && (cycCnt_d == LAST_CYCLE);
    assign count_d     = count_q + LW'(push) - LW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= encode(bus.in_data);
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cycCnt_q    <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            txLine_q    <= 1'b1;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycCnt_q    <= cycCnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            txLine_q    <= txLine_d;
            busy_q      <= busy_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.tx_line    = txLine_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frameDone_q;
    assign bus.fifo_level = count_q;
endmodule

// File: tb/tb_ecc_serial_tx.sv
// Scoreboard bench for ecc_serial_tx: a driver queues expected codewords on each accept,
// and an independent line monitor decodes every frame and checks it against the queue.
module tb_ecc_serial_tx;
    localparam int BC    = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 15 * BC;

    logic clk = 1'b0;
    logic rst = 1'b0;
`ifdef ECC_TX_ERR_INJECT_EN
    logic       injectErr = 1'b0;
    logic [3:0] injectBit = 4'd0;
`endif

    ecc_serial_tx_if #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) bus ();

    ecc_serial_tx #(
        .DATA_WIDTH(8),
        .ECC_WIDTH (5),
        .FIFO_DEPTH(DEPTH),
        .BIT_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ECC_TX_ERR_INJECT_EN
        .inject_err(injectErr),
        .inject_bit(injectBit),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [12:0] expQ [$];
    int checkCount  = 0;
    int errorCount  = 0;
    int pushCount   = 0;
    int popCount    = 0;
    int maxLevel    = 0;
    int contigCount = 0;

    // Reference codeword: each check bit is the parity of a fixed subset of data bits.
    function automatic logic [12:0] refCodeword(input logic [7:0] d);
        logic [4:0] e;
        e[0] = 1'($countones(d & 8'h5B) % 2);
        e[1] = 1'($countones(d & 8'h6D) % 2);
        e[2] = 1'($countones(d & 8'h8E) % 2);
        e[3] = 1'($countones(d & 8'hF0) % 2);
        e[4] = 1'($countones({e[3:0], d}) % 2);
        return {e, d};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called just after a negedge; returns at the negedge following the accepting edge.
    task automatic applyStimulus(input logic [7:0] d, input logic [12:0] flipMask);
        logic r;
        bit   done;
        done = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            r = bus.in_ready;
            @(posedge clk);
            if (r) begin
                expQ.push_back(refCodeword(d) ^ flipMask);
                pushCount++;
                done = 1;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept of 0x%0h", d);
        end
    endtask

    task automatic waitDrain(input int maxCycles);
        bit done;
        done = 0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !bus.busy) done = 1;
        end
        if (!done) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL drain_timeout: got %0d frames pending, expected 0", expQ.size());
        end
    endtask

    task automatic applyReset(input string tag);
        rst = 1'b1;
        #1;
        checkOutput({tag, "_tx_line"}, 32'(bus.tx_line), 32'd1);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        checkOutput({tag, "_fifo_level"}, 32'(bus.fifo_level), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        expQ.delete();
        pushCount = 0;
        popCount  = 0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    // Line monitor: records each frame cycle by cycle, then decodes and scores it.
    initial begin : monitor
        logic        txS   [FRAME];
        logic        busyS [FRAME];
        logic        fdS   [FRAME];
        logic [12:0] cw;
        logic [12:0] expCw;
        bit          inFrame;
        bit          good;
        logic        prevTx;
        int          fc;
        int          gap;
        int          b;
        int          expLevel;
        inFrame = 0;
        prevTx  = 1'b1;
        fc      = 0;
        gap     = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                inFrame = 0;
                prevTx  = 1'b1;
                gap     = 1;
            end else begin
                if (!inFrame && bus.tx_line == 1'b0 && prevTx == 1'b1) begin
                    inFrame = 1;
                    fc      = 0;
                    popCount++;
                    if (gap == 0) contigCount++;
                end
                if (inFrame) begin
                    txS[fc]   = bus.tx_line;
                    busyS[fc] = bus.busy;
                    fdS[fc]   = bus.frame_done;
                    fc++;
                    if (fc == FRAME) begin
                        good = 1;
                        cw   = '0;
                        for (int c = 0; c < FRAME; c++) begin
                            b = c / BC;
                            if (busyS[c] !== 1'b1) good = 0;
                            if (fdS[c] !== (c == FRAME - 1)) good = 0;
                            if (b == 0 && txS[c] !== 1'b0) good = 0;
                            if (b == 14 && txS[c] !== 1'b1) good = 0;
                            if (b >= 1 && b <= 13) begin
                                if (c % BC == 0) cw[b-1] = txS[c];
                                else if (txS[c] !== cw[b-1]) good = 0;
                            end
                        end
                        checkOutput("frame_format", 32'(good), 32'd1);
                        if (expQ.size() == 0) begin
                            checkCount++;
                            errorCount++;
                            $display("[TB] FAIL unexpected_frame: got 0x%0h, expected no frame", cw);
                        end else begin
                            expCw = expQ.pop_front();
                            checkOutput("codeword", 32'(cw), 32'(expCw));
                        end
                        inFrame = 0;
                        gap     = 0;
                    end
                end else begin
                    gap++;
                    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
                    checkOutput("idle_frame_done", 32'(bus.frame_done), 32'd0);
                end
                expLevel = pushCount - popCount;
                checkOutput("fifo_level", 32'(bus.fifo_level), 32'(expLevel));
                checkOutput("in_ready", 32'(bus.in_ready), 32'(expLevel < DEPTH));
                if (int'(bus.fifo_level) > maxLevel) maxLevel = int'(bus.fifo_level);
                prevTx = bus.tx_line;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int          c0;
        logic [7:0]  w;
        bit          seen;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        #1;
        applyReset("reset");

        // Single word: latency to start bit, then the full frame via the monitor.
        applyStimulus(8'hA5, 13'h0);
        checkOutput("latency_pre", 32'(bus.tx_line), 32'd1);
        @(negedge clk);
        checkOutput("latency_start", 32'(bus.tx_line), 32'd0);
        waitDrain(FRAME * 2);
        checkOutput("busy_after", 32'(bus.busy), 32'd0);

        // Back-to-back words give contiguous frames.
        c0 = contigCount;
        maxLevel = 0;
        applyStimulus(8'h00, 13'h0);
        applyStimulus(8'hFF, 13'h0);
        applyStimulus(8'h01, 13'h0);
        waitDrain(FRAME * 5);
        checkOutput("b2b_contiguous", 32'(contigCount - c0), 32'd2);
        checkOutput("b2b_peak", 32'(maxLevel), 32'd2);

        // Six words held against a busy line fill the FIFO.
        maxLevel = 0;
        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            applyStimulus(w, 13'h0);
        end
        waitDrain(FRAME * 8);
        checkOutput("full_peak", 32'(maxLevel), 32'd4);

        // Push coinciding with the STOP-exit pop at level 2.
        applyStimulus(8'h11, 13'h0);
        applyStimulus(8'h22, 13'h0);
        applyStimulus(8'h33, 13'h0);
        seen = 0;
        for (int i = 0; i < FRAME + 10 && !seen; i++) begin
            if (bus.frame_done) seen = 1;
            else @(negedge clk);
        end
        checkOutput("frame_done_seen", 32'(seen), 32'd1);
        applyStimulus(8'h5A, 13'h0);
        checkOutput("same_cycle_level", 32'(bus.fifo_level), 32'd2);
        waitDrain(FRAME * 5);

        // Reset during data bit 5 with two words queued.
        applyStimulus(8'hC3, 13'h0);
        applyStimulus(8'h3C, 13'h0);
        applyStimulus(8'h96, 13'h0);
        repeat (26) @(negedge clk);
        #1;
        applyReset("midframe");
        applyStimulus(8'h7E, 13'h0);
        waitDrain(FRAME * 2);

        // Randomized stream with random inter-word gaps.
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w = 8'($urandom);
            applyStimulus(w, 13'h0);
        end
        waitDrain(FRAME * 30);

`ifdef ECC_TX_ERR_INJECT_EN
        injectErr = 1'b1;
        injectBit = 4'd4;
        applyStimulus(8'hA5, 13'h0010);
        @(negedge clk);
        injectErr = 1'b0;
        waitDrain(FRAME * 2);
        injectErr = 1'b1;
        injectBit = 4'd13;
        applyStimulus(8'hA5, 13'h0000);
        @(negedge clk);
        injectErr = 1'b0;
        waitDrain(FRAME * 2);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
